// File: rtl/parking_pkg.sv
// parking_pkg: shared types and default constants for the parking gate
// scheduler.
//   state_t   gate sequencing states (IDLE, GRANT, OPEN, CLOSE)
//   dir_t     direction the gate was granted to (ENTRY, EXIT)
//   *_DEF     default parameter values for the scheduler
//   timer_w   counter width needed to hold a given maximum value
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OPEN  = 2'd2,
    CLOSE = 2'd3
  } state_t;

  typedef enum logic {
    ENTRY = 1'b0,
    EXIT  = 1'b1
  } dir_t;

  localparam int CAPACITY_DEF     = 3;
  localparam int CNT_W_DEF        = 2;
  localparam int OPEN_CYCLES_DEF  = 16;
  localparam int CLOSE_CYCLES_DEF = 4;

  // Bits needed to hold max_val; never less than 1.
  function automatic int timer_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gate_timer.sv
// gate_timer: load/decrement down-counter with a zero flag.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (count clears to 0)
//   load       load load_val (takes priority over dec)
//   load_val   value to load
//   dec        decrement by one; holds at zero
//   zero       high while the count is zero
module gate_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler: sequences one shared barrier gate between an entry
// and an exit requester and owns the lot occupancy count.
//
// Build option: GATE_TIMEOUT_EN -- when defined, an open phase without a
// car_pass is aborted after OPEN_CYCLES cycles (timeout pulse, gate closes,
// occupancy unchanged). When undefined, OPEN waits for car_pass forever and
// timeout is tied low.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   entry_req    pulse: car waiting at entry sensor
//   exit_req     pulse: car waiting at exit sensor
//   car_pass     pulse: car cleared the gate (only honoured in OPEN)
//   gate_open    barrier actuator level, high in OPEN
//   grant_entry  pulse in GRANT when entry won
//   grant_exit   pulse in GRANT when exit won
//   busy         high whenever not IDLE
//   occupancy    occupied slot count
//   full, empty  occupancy == CAPACITY / occupancy == 0
//   alarm        pulse when a pending request was rejected
//   timeout      pulse when the open phase was aborted
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int CAPACITY     = CAPACITY_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int OPEN_CYCLES  = OPEN_CYCLES_DEF,
  parameter int CLOSE_CYCLES = CLOSE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_pass,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             busy,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             alarm,
  output logic             timeout
);

  if (CAPACITY < 1 || OPEN_CYCLES < 1 || CLOSE_CYCLES < 1 ||
      (2 ** CNT_W) <= CAPACITY) begin : g_bad_params
    $error("parking_gate_scheduler: illegal parameter combination");
  end

  localparam int                 CLOSE_W    = timer_w(CLOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CAP_VAL    = CNT_W'(CAPACITY);
  localparam logic [CLOSE_W-1:0] CLOSE_LOAD = CLOSE_W'(CLOSE_CYCLES - 1);

  state_t state, state_nxt;
  dir_t   dir, last_served;
  logic   pend_entry, pend_exit;
  logic   alarm_q;

  logic   idle, in_grant, in_open, in_close;
  logic   entry_ok, exit_ok, entry_bad, exit_bad;
  logic   win_entry, win_exit, any_win;
  logic   clr_entry, clr_exit, reject;
  logic   pass, open_expire, open_done;
  logic   close_zero;

  assign idle     = (state == IDLE);
  assign in_grant = (state == GRANT);
  assign in_open  = (state == OPEN);
  assign in_close = (state == CLOSE);

  assign full      = (occupancy == CAP_VAL);
  assign empty     = (occupancy == '0);
  assign gate_open = in_open;
  assign busy      = !idle;
  assign grant_entry = in_grant && (dir == ENTRY);
  assign grant_exit  = in_grant && (dir == EXIT);
  assign alarm       = alarm_q;

  // Request evaluation only happens in IDLE, against the occupancy that
  // already includes the last pass.
  assign entry_ok  = idle && pend_entry && !full;
  assign exit_ok   = idle && pend_exit  && !empty;
  assign entry_bad = idle && pend_entry && full;
  assign exit_bad  = idle && pend_exit  && empty;

  // Round-robin: with both valid, the side not served last time wins.
  assign win_entry = entry_ok && (!exit_ok || last_served == EXIT);
  assign win_exit  = exit_ok && !win_entry;
  assign any_win   = win_entry || win_exit;

  assign clr_entry = entry_bad || win_entry;
  assign clr_exit  = exit_bad  || win_exit;
  assign reject    = entry_bad || exit_bad;

  assign pass      = in_open && car_pass;
  assign open_done = pass || open_expire;

`ifdef GATE_TIMEOUT_EN
  localparam int                OPEN_W    = timer_w(OPEN_CYCLES - 1);
  localparam logic [OPEN_W-1:0] OPEN_LOAD = OPEN_W'(OPEN_CYCLES - 1);

  logic open_zero;
  logic timeout_q;

  // Loaded in GRANT so the first OPEN cycle sees OPEN_CYCLES-1; expiry is
  // the OPEN cycle where the count sits at zero, giving OPEN_CYCLES cycles.
  gate_timer #(.W(OPEN_W)) u_open_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (in_grant),
    .load_val (OPEN_LOAD),
    .dec      (in_open),
    .zero     (open_zero)
  );

  // car_pass on the expiry cycle takes precedence over the abort.
  assign open_expire = in_open && open_zero && !car_pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= open_expire;
  end

  assign timeout = timeout_q;
`else
  assign open_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Loaded on the OPEN->CLOSE edge; CLOSE exits on the zero cycle, so it
  // lasts exactly CLOSE_CYCLES cycles.
  gate_timer #(.W(CLOSE_W)) u_close_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (open_done),
    .load_val (CLOSE_LOAD),
    .dec      (in_close),
    .zero     (close_zero)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_win)    state_nxt = GRANT;
      GRANT:                   state_nxt = OPEN;
      OPEN:    if (open_done)  state_nxt = CLOSE;
      CLOSE:   if (close_zero) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dir         <= ENTRY;
      last_served <= EXIT;
      pend_entry  <= 1'b0;
      pend_exit   <= 1'b0;
      alarm_q     <= 1'b0;
      occupancy   <= '0;
    end else begin
      state   <= state_nxt;
      alarm_q <= reject;
      // A fresh pulse on the clearing cycle re-arms the request.
      pend_entry <= entry_req || (pend_entry && !clr_entry);
      pend_exit  <= exit_req  || (pend_exit  && !clr_exit);
      if (any_win) begin
        dir         <= win_entry ? ENTRY : EXIT;
        last_served <= win_entry ? ENTRY : EXIT;
      end
      // Validity checks before GRANT keep this inside 0..CAPACITY.
      if (pass) begin
        if (dir == ENTRY) occupancy <= occupancy + CNT_W'(1);
        else              occupancy <= occupancy - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler. Pulse outputs (grants, alarm,
// timeout) are predicted into a scoreboard queue with their expected cycle
// when the stimulus is driven and popped by a monitor when they appear.
module tb_parking_gate_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       entry_req, exit_req, car_pass;
  logic       gate_open, grant_entry, grant_exit, busy;
  logic [1:0] occupancy;
  logic       full, empty, alarm, timeout;

  parking_gate_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .car_pass    (car_pass),
    .gate_open   (gate_open),
    .grant_entry (grant_entry),
    .grant_exit  (grant_exit),
    .busy        (busy),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .alarm       (alarm),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] EV_GE = 4'b0001;
  localparam logic [3:0] EV_GX = 4'b0010;
  localparam logic [3:0] EV_AL = 4'b0100;
  localparam logic [3:0] EV_TO = 4'b1000;

  typedef struct {
    logic [3:0] ev;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [3:0] mon_ev;
  exp_t       mon_exp;
  logic [1:0] occ_now;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] ev, input int off);
    exp_t e;
    e.ev  = ev;
    e.cyc = cyc + off;
    sb.push_back(e);
  endtask

  // Every pulse the DUT emits must be the next predicted one, on its cycle.
  always @(negedge clk) begin
    mon_ev = {timeout, alarm, grant_exit, grant_entry};
    if (!rst && mon_ev != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {28'd0, mon_ev}, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("event_kind", {28'd0, mon_ev}, {28'd0, mon_exp.ev});
        check("event_cycle", cyc, mon_exp.cyc);
      end
    end
  end

  // Full grant/open/pass/close transaction from idle.
  task automatic serve(input bit is_entry, input logic [1:0] exp_occ);
    if (is_entry) begin entry_req = 1'b1; push(EV_GE, 2); end
    else          begin exit_req  = 1'b1; push(EV_GX, 2); end
    tick(1);
    entry_req = 1'b0; exit_req = 1'b0;
    tick(1);
    check("serve_busy_grant", busy, 1);
    check("serve_gate_grant", gate_open, 0);
    tick(1);
    check("serve_gate_open", gate_open, 1);
    tick(1);
    car_pass = 1'b1;
    tick(1);
    car_pass = 1'b0;
    check("serve_gate_closed", gate_open, 0);
    check("serve_occ", occupancy, exp_occ);
    tick(3);
    check("serve_busy_close_end", busy, 1);
    tick(1);
    check("serve_idle", busy, 0);
  endtask

  task automatic reject(input bit is_entry, input logic [1:0] exp_occ);
    if (is_entry) entry_req = 1'b1;
    else          exit_req  = 1'b1;
    push(EV_AL, 2);
    tick(1);
    entry_req = 1'b0; exit_req = 1'b0;
    tick(1);
    check("reject_gate", gate_open, 0);
    check("reject_busy", busy, 0);
    tick(2);
    check("reject_occ", occupancy, exp_occ);
    check("reject_still_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; car_pass = 1'b0;
    tick(2);
    check("rst_gate", gate_open, 0);
    check("rst_busy", busy, 0);
    check("rst_occ", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_pulses", {alarm, timeout, grant_entry, grant_exit}, 0);
    rst = 1'b0;
    tick(1);

    // Exit from an empty lot is rejected.
    reject(1'b0, 2'd0);

    // Basic entry, then fill the lot.
    serve(1'b1, 2'd1);
    check("occ1_empty", empty, 0);
    serve(1'b1, 2'd2);
    serve(1'b1, 2'd3);
    check("full_flag", full, 1);

    // Entry into a full lot is rejected.
    reject(1'b1, 2'd3);

    // Drain to 1; last_served is now EXIT.
    serve(1'b0, 2'd2);
    serve(1'b0, 2'd1);

    // Simultaneous requests: entry wins, exit follows after CLOSE.
    // A repeated exit pulse while pending must be absorbed.
    entry_req = 1'b1; exit_req = 1'b1;
    push(EV_GE, 2);
    push(EV_GX, 10);
    tick(1);
    entry_req = 1'b0; exit_req = 1'b0;
    tick(2);
    check("sim_gate_entry", gate_open, 1);
    exit_req = 1'b1;
    tick(1);
    exit_req = 1'b0;
    car_pass = 1'b1;
    tick(1);
    car_pass = 1'b0;
    check("sim_occ_after_entry", occupancy, 2);
    tick(5);
    check("sim_busy_exit_grant", busy, 1);
    tick(1);
    check("sim_gate_exit", gate_open, 1);
    car_pass = 1'b1;
    tick(1);
    car_pass = 1'b0;
    check("sim_occ_final", occupancy, 1);
    tick(4);
    check("sim_idle", busy, 0);

    // Open phase without a car_pass.
    entry_req = 1'b1;
    push(EV_GE, 2);
`ifdef GATE_TIMEOUT_EN
    push(EV_TO, 19);
`endif
    tick(1);
    entry_req = 1'b0;
    tick(2);
    check("to_gate_open", gate_open, 1);
`ifdef GATE_TIMEOUT_EN
    tick(15);
    check("to_last_open", gate_open, 1);
    tick(1);
    check("to_gate_closed", gate_open, 0);
    check("to_occ_same", occupancy, 1);
    tick(4);
    check("to_idle", busy, 0);
    occ_now = 2'd1;
`else
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("no_to_gate_held", gate_open, 1);
    end
    car_pass = 1'b1;
    tick(1);
    car_pass = 1'b0;
    check("no_to_occ", occupancy, 2);
    tick(4);
    check("no_to_idle", busy, 0);
    occ_now = 2'd2;
`endif
    check("occ_before_rst", occupancy, occ_now);

    // Reset in OPEN with an exit pending.
    entry_req = 1'b1;
    push(EV_GE, 2);
    tick(1);
    entry_req = 1'b0;
    tick(2);
    check("mr_gate_open", gate_open, 1);
    exit_req = 1'b1;
    tick(1);
    exit_req = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_gate_drop", gate_open, 0);
    check("mr_occ", occupancy, 0);
    check("mr_busy", busy, 0);
    tick(1);
    rst = 1'b0;
    tick(8);
    check("mr_no_regrant", busy, 0);
    check("mr_gate_after", gate_open, 0);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
